rr_arbiter_4: RTL

Four-requester round-robin arbiter that shares one 4:1 data-selection path between independent sources and presents the winner on a single valid/ready output channel. It owns the mux select and drives it from a registered grant, so the selected data is stable for the whole transaction. It sits between four producer lanes and one downstream consumer in the combinational-datapath library.

---
 rtl/rr_arbiter_4.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 - four-lane round-robin arbiter with an owned 4:1 data mux.
//
// The winner is presented on a single valid/ready channel. The grant and the
// mux select are registered, so the selected lane data stays stable for the
// whole transfer.
//
// Optional feature macro: ARB_LOCK_EN
//   When defined, a lock[3:0] input is added. A locked lane that is still
//   requesting keeps the grant across acceptances (burst ownership).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [3:0]     per-lane request
//   din        in   [4*DW-1:0] packed lane data, lane i at din[i*DW +: DW]
//   gnt        out  [3:0]     registered one-hot grant, zero when idle
//   ack        out  [3:0]     one-hot transfer-complete strobe
//   sel        out  [1:0]     registered mux select (granted lane)
//   out_valid  out            downstream valid, high while a grant is held
//   out_ready  in             downstream ready
//   dout       out  [DW-1:0]  din lane indexed by sel
//   lock       in   [3:0]     per-lane hold request (ARB_LOCK_EN only)
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | no grant held, waiting for any request
// S_GRANT | one lane granted, waiting for out_ready

module rr_arbiter_4 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
    output logic [3:0]      gnt,
    output logic [3:0]      ack,
    output logic [1:0]      sel,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef ARB_LOCK_EN
    input  logic [3:0]      lock,
`endif
    output logic [DW-1:0]   dout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;

    logic       accept;
    logic       hold;
    logic [2:0] pick_idle;
    logic [2:0] pick_next;

    // Returns {found, lane}: first asserted request scanning p, p+1, ... mod 4.
    // The loop runs downward so the lowest offset is the last one written.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign out_valid = (state_q == S_GRANT);
    assign accept    = out_valid & out_ready;
    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign ack       = gnt_q & {4{accept}};
    assign dout      = din[int'(sel_q)*DW +: DW];

`ifdef ARB_LOCK_EN
    assign hold = lock[sel_q] & req[sel_q];
`else
    assign hold = 1'b0;
`endif

    // Idle arbitration uses the stored pointer; post-acceptance arbitration
    // uses the pointer that is about to be written, so there is no bubble.
    assign pick_idle = rr_pick(req, ptr_q);
    assign pick_next = rr_pick(req, sel_q + 2'd1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_idle[2]) begin
                    sel_d   = pick_idle[1:0];
                    gnt_d   = 4'b0001 << pick_idle[1:0];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (accept && !hold) begin
                    ptr_d = sel_q + 2'd1;
                    if (pick_next[2]) begin
                        sel_d = pick_next[1:0];
                        gnt_d = 4'b0001 << pick_next[1:0];
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = S_IDLE;
                    end
                end
                // A locked, still-requesting lane keeps grant, select and pointer.
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule
